cnu_serial: RTL and testbench

CNU_SERIAL -- requirements
Module: cnu_serial

---
 rtl/cnu_serial.sv | 169 ++++++++++++++++
 tb/tb_cnu_serial.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cnu_serial.sv
// cnu_serial: serial min-sum check-node unit.
// Collects one check node's messages, then emits one reply per input.
module cnu_serial #(
    parameter int D      = 8,
    parameter int data_w = 8,
    parameter int MODE   = 0,
    parameter int BETA   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [data_w-1:0] q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [data_w-1:0] r
);
    localparam int CW = $clog2(D + 1);
    localparam logic [data_w-1:0] MAXM = {1'b0, {(data_w-1){1'b1}}};
    localparam logic [data_w-1:0] MINV = {1'b1, {(data_w-1){1'b0}}};

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     j_q, j_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [data_w-1:0] min_q, min_d;
    logic [data_w-1:0] min2_q, min2_d;
    logic              rsgn_q, rsgn_d;
    logic [D-1:0]      sgn_q, sgn_d;
    logic [data_w-1:0] r_q, r_d;
    logic              ov_q, ov_d;
    logic              ol_q, ol_d;
    logic              ir_q, ir_d;
    logic [data_w-1:0] q_mag;
    logic [data_w-1:0] m_sel;
    logic              s_j;

    // Scale or offset a magnitude, then apply the reply sign (no -0).
    function automatic logic [data_w-1:0] shape(
        input logic [data_w-1:0] m,
        input logic              neg
    );
        logic [data_w-1:0] mag;
        if (MODE == 0) begin
            mag = data_w'((({2'b00, m} << 1) + {2'b00, m}) >> 2);
        end else begin
            mag = (m > data_w'(BETA)) ? m - data_w'(BETA) : '0;
        end
        return (neg && mag != '0) ? -mag : mag;
    endfunction

    // Saturating magnitude of the incoming message.
    always_comb begin
        if (q == MINV) begin
            q_mag = MAXM;
        end else if (q[data_w-1]) begin
            q_mag = -q;
        end else begin
            q_mag = q;
        end
    end

    // Next-state: collect min/min2/parity, then walk the reply index.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        j_d     = j_q;
        idx_d   = idx_q;
        min_d   = min_q;
        min2_d  = min2_q;
        rsgn_d  = rsgn_q;
        sgn_d   = sgn_q;
        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    for (int i = 0; i < D; i++) begin
                        if (k_q == CW'(i)) sgn_d[i] = q[data_w-1];
                    end
                    rsgn_d = rsgn_q ^ q[data_w-1];
                    if (q_mag < min_q) begin
                        min2_d = min_q;
                        min_d  = q_mag;
                        idx_d  = k_q;
                    end else if (q_mag < min2_q) begin
                        min2_d = q_mag;
                    end
                    if (in_last || k_q == CW'(D - 1)) begin
                        state_d = EMIT;
                        n_d     = k_q + CW'(1);
                        j_d     = '0;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (j_q == n_q - CW'(1)) begin
                        state_d = COLLECT;
                        j_d     = '0;
                        idx_d   = '0;
                        min_d   = MAXM;
                        min2_d  = MAXM;
                        rsgn_d  = 1'b0;
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        s_j = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (j_d == CW'(i)) s_j = sgn_d[i];
        end
        m_sel = (j_d == idx_d) ? min2_d : min_d;
        ov_d  = (state_d == EMIT);
        ir_d  = (state_d == COLLECT);
        ol_d  = ov_d && (j_d == n_d - CW'(1));
        r_d   = ov_d ? shape(m_sel, rsgn_d ^ s_j) : '0;
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            k_q     <= '0;
            n_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            min_q   <= MAXM;
            min2_q  <= MAXM;
            rsgn_q  <= 1'b0;
            sgn_q   <= '0;
            r_q     <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            ir_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            min2_q  <= min2_d;
            rsgn_q  <= rsgn_d;
            sgn_q   <= sgn_d;
            r_q     <= r_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            ir_q    <= ir_d;
        end
    end

    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign out_last  = ol_q;
    assign r         = r_q;

endmodule

// File: tb/tb_cnu_serial.sv
// tb_cnu_serial: directed and random check-node traffic against a
// sort-free reference model, for both normalized and offset modes.
module tb_cnu_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] q = '0;
    logic       ir0, ov0, ol0, ir1, ov1, ol1;
    logic [7:0] r0, r1;

    int ncomp = 0;
    int nfail = 0;
    int exp0[$];
    int exp1[$];

    always #5 clk = ~clk;

    cnu_serial #(.D(8), .data_w(8), .MODE(0), .BETA(1)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir0), .in_last(in_last), .q(q),
        .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .r(r0)
    );

    cnu_serial #(.D(8), .data_w(8), .MODE(1), .BETA(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1), .in_last(in_last), .q(q),
        .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .r(r1)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Extrinsic min-sum: each reply uses the smallest magnitude among
    // the OTHER inputs and the parity of the OTHER signs.
    function automatic void model(input int vals[$]);
        int n;
        int mg[$];
        n = vals.size();
        exp0.delete();
        exp1.delete();
        foreach (vals[i]) begin
            int m;
            m = (vals[i] < 0) ? -vals[i] : vals[i];
            if (m > 127) m = 127;
            mg.push_back(m);
        end
        for (int j = 0; j < n; j++) begin
            int mo, a, b;
            bit neg;
            mo = 127;
            neg = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (i != j) begin
                    if (mg[i] < mo) mo = mg[i];
                    if (vals[i] < 0) neg = ~neg;
                end
            end
            a = (mo * 3) / 4;
            b = (mo > 1) ? mo - 1 : 0;
            if (neg) begin
                a = -a;
                b = -b;
            end
            exp0.push_back(a);
            exp1.push_back(b);
        end
    endfunction

    task automatic send_node(input int vals[$], input bit use_last);
        for (int i = 0; i < vals.size(); i++) begin
            @(negedge clk);
            chk("in_ready0", ir0, 1);
            chk("in_ready1", ir1, 1);
            in_valid = 1'b1;
            q        = 8'(vals[i]);
            in_last  = use_last && (i == vals.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        q        = '0;
    endtask

    task automatic recv_node(input int n, input int sj, input int sl);
        int j, st, cyc;
        j = 0;
        st = 0;
        cyc = 0;
        while (j < n && cyc < 64) begin
            cyc++;
            chk("out_valid0", ov0, 1);
            chk("out_valid1", ov1, 1);
            chk("in_ready_emit", ir0, 0);
            chk("r_mode0", $signed(r0), exp0[j]);
            chk("r_mode1", $signed(r1), exp1[j]);
            chk("out_last0", ol0, (j == n - 1));
            chk("out_last1", ol1, (j == n - 1));
            if (j == sj && st < sl) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
                j++;
            end
            @(negedge clk);
        end
        chk("emit_count", j, n);
        out_ready = 1'b0;
        chk("done_valid", ov0, 0);
        chk("done_ready", ir0, 1);
    endtask

    task automatic run_node(input int vals[$], input bit use_last,
                            input int sj, input int sl);
        model(vals);
        send_node(vals, use_last);
        recv_node(vals.size(), sj, sl);
    endtask

    initial begin
        int v[$];

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_last", ol0, 0);
        chk("rst_r", r0, 0);
        chk("rst_in_ready", ir0, 1);
        chk("rst_in_ready1", ir1, 1);
        rst = 1'b1;

        v = '{10, -4, 7, -20};
        run_node(v, 1'b1, 2, 5);

        v = '{-128, 5};
        run_node(v, 1'b1, -1, 0);

        v = '{2, 2, 2, 2, 2, 2, 2, 2};
        run_node(v, 1'b0, -1, 0);

        v = '{-60};
        run_node(v, 1'b1, 0, 2);

        v = '{10, -4, 7, -20};
        model(v);
        send_node(v, 1'b1);
        chk("pre_rst_r0", $signed(r0), exp0[0]);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_r1", $signed(r0), exp0[1]);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", ov0, 0);
        chk("mid_rst_ready", ir0, 1);
        chk("mid_rst_r", r0, 0);
        chk("mid_rst_last", ol0, 0);
        chk("mid_rst_valid1", ov1, 0);
        rst = 1'b1;
        out_ready = 1'b0;

        v = '{-3, 50, 9};
        run_node(v, 1'b1, -1, 0);

        for (int t = 0; t < 40; t++) begin
            int n;
            bit ul;
            n = int'($urandom_range(1, 8));
            v.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1)
                    v.push_back(int'($urandom_range(0, 8)) - 4);
                else
                    v.push_back(int'($urandom_range(0, 255)) - 128);
            end
            ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            run_node(v, ul, int'($urandom_range(0, 9)) - 1,
                     int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end
endmodule
